// File: rtl/hilo_divider_pkg.sv
// Shared CPU definitions for the HI/LO divide unit: default operand width and FSM encoding.
// Pure declarations; no logic, no latency, no flow control.
package hilo_divider_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/hilo_divider_div_step.sv
// One restoring-division iteration on magnitudes: shift in the next dividend bit, trial subtract, restore.
// Purely combinational, zero latency; no flow control.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor_mag,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // With rem_in < divisor_mag the trial difference fits in WIDTH+1 bits, so its MSB is the borrow.
   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      diff    = shifted - {1'b0, divisor_mag};
      if (diff[WIDTH]) begin
         rem_out = shifted[WIDTH-1:0];
         quo_out = {quo_in[WIDTH-2:0], 1'b0};
      end else begin
         rem_out = diff[WIDTH-1:0];
         quo_out = {quo_in[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/hilo_divider.sv
// Iterative signed/unsigned divider producing LO (quotient) and HI (remainder).
// Fixed latency: done pulses WIDTH+1 cycles after start; busy stalls the pipeline during RUN, cancel aborts.
module hilo_divider
   import hilo_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             op_div,
   input  logic             op_divu,
   input  logic             cancel,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             div0_q, div0_d;
   logic [WIDTH-1:0] res_quo_q, res_quo_d;
   logic [WIDTH-1:0] res_rem_q, res_rem_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;

   logic [WIDTH-1:0] step_rem, step_quo;
   logic             start_signed, dvd_neg, dvs_neg;

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in      (rem_q),
      .quo_in      (quo_q),
      .divisor_mag (dvs_q),
      .rem_out     (step_rem),
      .quo_out     (step_quo)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rem_d        = rem_q;
      quo_d        = quo_q;
      dvs_d        = dvs_q;
      dvd_d        = dvd_q;
      qneg_d       = qneg_q;
      rneg_d       = rneg_q;
      div0_d       = div0_q;
      res_quo_d    = res_quo_q;
      res_rem_d    = res_rem_q;
      quotient_d   = quotient_q;
      remainder_d  = remainder_q;
      start_signed = op_div;
      dvd_neg      = op_div & dividend[WIDTH-1];
      dvs_neg      = op_div & divisor[WIDTH-1];

      case (state_q)
         IDLE: begin
            if ((op_div || op_divu) && !cancel) begin
               state_d = RUN;
               cnt_d   = '0;
               rem_d   = '0;
               quo_d   = dvd_neg ? (~dividend + 1'b1) : dividend;
               dvs_d   = dvs_neg ? (~divisor + 1'b1) : divisor;
               dvd_d   = dividend;
               qneg_d  = start_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               rneg_d  = dvd_neg;
               div0_d  = (divisor == '0);
            end
         end
         RUN: begin
            if (cancel) begin
               state_d = IDLE;
            end else begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) begin
                  state_d = DONE;
                  // Divide-by-zero bypasses sign fix-up so remainder is the raw dividend.
                  if (div0_q) begin
                     res_quo_d = '1;
                     res_rem_d = dvd_q;
                  end else begin
                     res_quo_d = qneg_q ? (~step_quo + 1'b1) : step_quo;
                     res_rem_d = rneg_q ? (~step_rem + 1'b1) : step_rem;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!cancel) begin
               quotient_d  = res_quo_q;
               remainder_d = res_rem_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         dvd_q       <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         div0_q      <= 1'b0;
         res_quo_q   <= '0;
         res_rem_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         dvd_q       <= dvd_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         div0_q      <= div0_d;
         res_quo_q   <= res_quo_d;
         res_rem_q   <= res_rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   // Results are presented in the DONE cycle itself so they are valid alongside the done pulse.
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE) && !cancel && !reset;
   assign quotient  = done ? res_quo_q : quotient_q;
   assign remainder = done ? res_rem_q : remainder_q;

endmodule

// File: tb/tb_hilo_divider.sv
// Bench for hilo_divider: vector table through a scoreboard plus hand sequences for cancel/reset corners.
module tb_hilo_divider;

   localparam int W  = 32;
   localparam int NV = 15;

   typedef struct {
      bit          sgn;
      bit          both;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } vec_t;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      int           start;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset, op_div, op_divu, cancel;
   logic [W-1:0] dividend, divisor;
   logic         busy, done;
   logic [W-1:0] quotient, remainder;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   busy_cnt = 0;
   exp_t sb[$];
   vec_t vecs[NV];

   hilo_divider #(.WIDTH(W)) dut (
      .clock     (clk),
      .reset     (reset),
      .op_div    (op_div),
      .op_divu   (op_divu),
      .cancel    (cancel),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard consumer: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!reset && busy) busy_cnt++;
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("latency", W'(cyc - e.start), W'(W + 1));
            chk("busy_cycles", W'(busy_cnt), W'(W));
            chk("busy_in_done", W'(busy), '0);
         end
      end
   end

   task automatic start_op(input bit s, input bit both, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit push, input logic [W-1:0] eq, input logic [W-1:0] er);
      exp_t e;
      @(negedge clk);
      op_div   = s | both;
      op_divu  = ~s | both;
      dividend = a;
      divisor  = b;
      if (push) begin
         e.q = eq;
         e.r = er;
         e.start = cyc;
         sb.push_back(e);
         busy_cnt = 0;
      end
      @(negedge clk);
      op_div   = 1'b0;
      op_divu  = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 80) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d results outstanding expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      reset = 1'b1; op_div = 1'b0; op_divu = 1'b0; cancel = 1'b0;
      dividend = '0; divisor = '0;

      vecs[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
      vecs[1]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
      vecs[2]  = '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
      vecs[3]  = '{1'b0, 1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
      vecs[4]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
      vecs[5]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
      vecs[6]  = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
      vecs[7]  = '{1'b0, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1};
      vecs[8]  = '{1'b1, 1'b0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
      vecs[9]  = '{1'b0, 1'b0, 32'd3,          32'd10,         32'd0,          32'd3};
      vecs[10] = '{1'b1, 1'b0, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0};
      vecs[11] = '{1'b0, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
      vecs[12] = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
      vecs[13] = '{1'b1, 1'b0, 32'h1234_5678,  32'h0000_0100,  32'h0012_3456,  32'h0000_0078};
      vecs[14] = '{1'b1, 1'b0, 32'hEDCB_A988,  32'h0000_0100,  32'hFFED_CBAA,  32'hFFFF_FF88};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_busy", W'(busy), '0);
      chk("reset_done", W'(done), '0);
      chk("reset_quotient", quotient, '0);
      chk("reset_remainder", remainder, '0);

      for (int i = 0; i < NV; i++) begin
         start_op(vecs[i].sgn, vecs[i].both, vecs[i].a, vecs[i].b, 1'b1, vecs[i].q, vecs[i].r);
         wait_idle();
      end

      // Cancel in the 10th RUN cycle: no done, previous 9/3 result held.
      start_op(1'b0, 1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0);
      wait_idle();
      start_op(1'b0, 1'b0, 32'd50, 32'd8, 1'b0, '0, '0);
      repeat (9) @(negedge clk);
      cancel = 1'b1;
      #1;
      chk("cancel_run_busy_before", W'(busy), 1);
      @(negedge clk);
      cancel = 1'b0;
      #1;
      chk("cancel_run_busy_after", W'(busy), '0);
      chk("cancel_run_done", W'(done), '0);
      chk("cancel_run_quotient", quotient, 32'd3);
      chk("cancel_run_remainder", remainder, 32'd0);
      start_op(1'b0, 1'b0, 32'd50, 32'd8, 1'b1, 32'd6, 32'd2);
      wait_idle();

      // Cancel landing on the DONE cycle suppresses the pulse and the update.
      start_op(1'b0, 1'b0, 32'd100, 32'd7, 1'b0, '0, '0);
      repeat (32) @(negedge clk);
      cancel = 1'b1;
      #1;
      chk("cancel_done_done", W'(done), '0);
      chk("cancel_done_quotient", quotient, 32'd6);
      @(negedge clk);
      cancel = 1'b0;
      #1;
      chk("cancel_done_busy", W'(busy), '0);
      chk("cancel_done_quotient_held", quotient, 32'd6);
      chk("cancel_done_remainder_held", remainder, 32'd2);

      // Start together with cancel in IDLE must not launch.
      @(negedge clk);
      op_divu = 1'b1; cancel = 1'b1; dividend = 32'd40; divisor = 32'd4;
      @(negedge clk);
      op_divu = 1'b0; cancel = 1'b0;
      #1;
      chk("cancel_idle_busy", W'(busy), '0);
      repeat (40) @(negedge clk);
      #1;
      chk("cancel_idle_quotient", quotient, 32'd6);

      // Start request during RUN is ignored and operands are not resampled.
      start_op(1'b0, 1'b0, 32'd20, 32'd3, 1'b1, 32'd6, 32'd2);
      repeat (3) @(negedge clk);
      op_div = 1'b1; dividend = 32'd1; divisor = 32'd1;
      @(negedge clk);
      op_div = 1'b0;
      wait_idle();

      // Reset in RUN cycle 5 discards the operation and clears the outputs.
      start_op(1'b0, 1'b0, 32'd1000, 32'd9, 1'b0, '0, '0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_run_busy", W'(busy), '0);
      chk("reset_run_done", W'(done), '0);
      chk("reset_run_quotient", quotient, '0);
      chk("reset_run_remainder", remainder, '0);
      repeat (40) @(negedge clk);
      #1;
      chk("reset_run_idle_busy", W'(busy), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hilo_divider.md
HILO_DIVIDER -- requirements
Module: hilo_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have op_div  input  1  start signed divide (DIV).
REQ-005 SHALL have op_divu  input  1  start unsigned divide (DIVU).
REQ-006 SHALL have cancel  input  1  pipeline flush; abort any operation in progress.
REQ-007 SHALL have dividend  input  WIDTH  numerator (rs), sampled only in the start cycle.
REQ-008 SHALL have divisor  input  WIDTH  denominator (rt), sampled only in the start cycle.
REQ-009 SHALL have busy  output  1  high while an operation is in progress; drives the pipeline stall.
REQ-010 SHALL have done  output  1  one-cycle pulse when results become valid.
REQ-011 SHALL have quotient  output  WIDTH  LO result, registered.
REQ-012 SHALL have remainder  output  WIDTH  HI result, registered.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 In IDLE, a cycle with op_div or op_divu high and cancel low SHALL be a start cycle: latch the operands and the signedness, go to RUN.
REQ-015 If op_div and op_divu are both high, the operation SHALL be signed.
REQ-016 Start requests in RUN or DONE SHALL be ignored; operands SHALL NOT be resampled.
REQ-017 RUN SHALL perform exactly WIDTH restoring iterations on operand magnitudes, one quotient bit per cycle (MSB first), then go to DONE.
REQ-018 In DONE, quotient and remainder SHALL be updated, done SHALL be high for exactly that cycle, and the next state SHALL be IDLE.
REQ-019 Latency SHALL be fixed: done high exactly WIDTH+1 cycles after the start cycle, independent of operand values.
REQ-020 busy SHALL be high in RUN only; it SHALL be low in IDLE and DONE.
REQ-021 Signed mode SHALL truncate toward zero: quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
REQ-022 Signed overflow (most-negative / -1) SHALL yield quotient = most-negative value and remainder = 0, with no exception.
REQ-023 Divide by zero (both modes) SHALL yield quotient = all ones and remainder = dividend, with normal latency.
REQ-024 cancel high in RUN SHALL return the block to IDLE on the next edge; done SHALL NOT pulse; quotient and remainder SHALL keep their prior values.
REQ-025 cancel high in DONE SHALL suppress the done pulse and the result update.
REQ-026 cancel high in IDLE together with a start request SHALL suppress the start.
REQ-027 quotient and remainder SHALL hold their values from DONE until the next DONE.

Reset
REQ-028 On reset, state SHALL go to IDLE and busy, done, quotient and remainder SHALL go to 0.
REQ-029 Reset SHALL take priority over start and cancel.
REQ-030 Reset during RUN SHALL discard the operation with no done pulse.

Structure
REQ-031 The state encoding and the DEFAULT_WIDTH constant (32) SHALL live in the shared CPU package.
REQ-032 The per-cycle shift/subtract/restore SHALL be a combinational sub-module named div_step, instantiated once.
REQ-033 Sign fix-up SHALL be performed in hilo_divider on entry to and exit from RUN, not inside div_step.

Verification
REQ-034 DIVU 100 / 7 -> done at start+33; quotient=14, remainder=2; busy high for exactly 32 cycles.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; DIVU 5 / 0 -> quotient=0xFFFFFFFF, remainder=5.
REQ-037 DIVU 9/3 completes (q=3, r=0); then start DIVU 50/8 and raise cancel at the 10th RUN cycle -> busy low next cycle, no done, outputs stay 3/0; a following DIVU 50/8 -> q=6, r=2.
REQ-038 Start DIVU 20/3, then pulse op_div with 1/1 during RUN -> ignored; result q=6, r=2 at start+33.
REQ-039 Assert reset at RUN cycle 5 -> next cycle busy=0, done=0, quotient=0, remainder=0, state IDLE.
